// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Purpose  : WIDTH-bit adder/subtractor built from GROUP-bit carry-lookahead
//            slices, one slice per pipeline stage, with valid/ready handshakes.
//            Define PIPELINED_CLA_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_CLA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int c_NSTAGE = WIDTH / GROUP;
    localparam int c_LAST   = c_NSTAGE - 1;

    // Lookahead slice: returns {carry_out, sum[GROUP-1:0]}.
    function automatic logic [GROUP:0] f_cla(
        input logic [GROUP-1:0] x,
        input logic [GROUP-1:0] y,
        input logic             ci
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            term     = 1'b1;
            c[i+1]   = g[i];
            for (int j = i; j >= 1; j--) begin
                term   = term & p[j];
                c[i+1] = c[i+1] | (term & g[j-1]);
            end
            c[i+1] = c[i+1] | (term & p[0] & ci);
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic             r_v   [c_NSTAGE];
    logic             r_c   [c_NSTAGE];
    logic [WIDTH-1:0] r_s   [c_NSTAGE];
    logic [WIDTH-1:0] r_a   [c_NSTAGE];
    logic [WIDTH-1:0] r_b   [c_NSTAGE];

    logic             w_vin [c_NSTAGE];
    logic             w_cin [c_NSTAGE];
    logic [WIDTH-1:0] w_sin [c_NSTAGE];
    logic [WIDTH-1:0] w_ain [c_NSTAGE];
    logic [WIDTH-1:0] w_bin [c_NSTAGE];
    logic [GROUP:0]   w_res [c_NSTAGE];
    logic             w_adv;

    assign w_adv     = !r_v[c_LAST] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[c_LAST];
    assign sum       = r_s[c_LAST];
    assign cout      = r_c[c_LAST];

    generate
        for (genvar k = 0; k < c_NSTAGE; k++) begin : g_stage
            if (k == 0) begin : g_first
                // Subtraction is a + ~b + 1, so the carry-in is forced high.
                assign w_vin[k] = in_valid;
                assign w_cin[k] = sub | cin;
                assign w_sin[k] = '0;
                assign w_ain[k] = a;
                assign w_bin[k] = sub ? ~b : b;
            end else begin : g_next
                assign w_vin[k] = r_v[k-1];
                assign w_cin[k] = r_c[k-1];
                assign w_sin[k] = r_s[k-1];
                assign w_ain[k] = r_a[k-1];
                assign w_bin[k] = r_b[k-1];
            end
            assign w_res[k] = f_cla(w_ain[k][k*GROUP +: GROUP],
                                    w_bin[k][k*GROUP +: GROUP],
                                    w_cin[k]);
        end
    endgenerate

    // Data only moves with a valid token so bubbles leave the registers quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < c_NSTAGE; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_s[k] <= '0;
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < c_NSTAGE; k++) begin
                r_v[k] <= w_vin[k];
                if (w_vin[k]) begin
                    r_c[k]                   <= w_res[k][GROUP];
                    r_a[k]                   <= w_ain[k];
                    r_b[k]                   <= w_bin[k];
                    r_s[k]                   <= w_sin[k];
                    r_s[k][k*GROUP +: GROUP] <= w_res[k][GROUP-1:0];
                end
            end
        end
    end

    // Last-stage operand copies have no reader.
    logic w_unused_ops;
    assign w_unused_ops = ^{r_a[c_LAST], r_b[c_LAST]};

`ifdef PIPELINED_CLA_OVF_EN
    logic w_ovf_nxt;
    logic r_ovf;

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign w_ovf_nxt = (w_res[c_LAST][GROUP-1] ^ w_ain[c_LAST][WIDTH-1]
                        ^ w_bin[c_LAST][WIDTH-1]) ^ w_res[c_LAST][GROUP];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv && w_vin[c_LAST]) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// Testbench for pipelined_cla_adder: randomized and directed stimulus with a
// scoreboard queue fed at acceptance and drained by an independent monitor.
module tb_pipelined_cla_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NS = W / G;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPELINED_CLA_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

`ifndef PIPELINED_CLA_OVF_EN
    assign ovf = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on W+1 bits, overflow from operand signs.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xc, input logic xs);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = xs ? ~xb : xb;
        full = {1'b0, xa} + {1'b0, bb} + ((xs || xc) ? (W+1)'(1) : (W+1)'(0));
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (xa[W-1] == bb[W-1]) && (full[W-1] != xa[W-1]);
        return e;
    endfunction

    // Monitor: compares the presented result with the oldest expectation every
    // cycle it is shown, pops it only when the consumer takes it.
    always begin
        @(negedge clk);
        #2;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                chk("result", {sum, cout}, {q[0].s, q[0].c});
`ifdef PIPELINED_CLA_OVF_EN
                chk("ovf", ovf, q[0].o);
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, input logic xs, input logic ordy, output logic acc);
        @(negedge clk);
        in_valid  = v;
        a         = xa;
        b         = xb;
        cin       = xc;
        sub       = xs;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) q.push_back(model(xa, xb, xc, xs));
    endtask

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic xs, input logic ordy);
        logic acc;
        int   n = 0;
        do begin
            drive(1'b1, xa, xb, xc, xs, ordy, acc);
            n++;
        end while (!acc && n < 100);
        chk("send_accept", acc, 1);
    endtask

    // Called right after an op is accepted at the next rising edge.
    task automatic check_latency(input string name, input logic [W-1:0] es,
                                 input logic ec, input logic eo);
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #3;
            chk({name, "_valid"}, out_valid, (k == NS - 1) ? 1 : 0);
        end
        chk({name, "_sum"}, {sum, cout}, {es, ec});
`ifdef PIPELINED_CLA_OVF_EN
        chk({name, "_ovf"}, ovf, eo);
`else
        if (eo) chk({name, "_ovf_unused"}, ovf, 0);
`endif
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while (q.size() != 0 && n < 60) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", {sum, cout}, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_ovf", ovf, 0);

        // Directed arithmetic with exact latency
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        check_latency("wrap", 16'h0000, 1'b1, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        check_latency("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
        send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
        check_latency("sub_noborrow", 16'h0002, 1'b1, 1'b0);
        drain();

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
            chk("stream_accept", acc, 1);
        end
        drain();

        // Random bubbles and random backpressure
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0), acc);
        end
        drain();

        // Fill the pipeline, then stall the output for three cycles
        for (int i = 0; i < NS; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, acc);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        send(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1);
        drain();

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NS + 2; i++) begin
            #1;
            chk("flush_out_valid", out_valid, 0);
            chk("flush_in_ready", in_ready, 1);
            chk("flush_sum", sum, 0);
            @(negedge clk);
        end
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        check_latency("after_reset", 16'h2345, 1'b0, 1'b0);
        drain();

`ifdef PIPELINED_CLA_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        check_latency("ovf_add", 16'h8000, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        check_latency("ovf_sub", 16'h7FFF, 1'b1, 1'b1);
        send(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
        check_latency("ovf_none", 16'h0007, 1'b0, 1'b0);
        drain();
`endif

        repeat (NS + 2) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        chk("final_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
